// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results with queued load returns into
// one registered register-file write per cycle, plus a pending-write query for issue.
module wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [4:0]               alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [4:0]               ld_rd,
    input  logic [XLEN-1:0]          ld_data,
    output logic                     RegW,
    output logic [4:0]               Rd,
    output logic [XLEN-1:0]          Wd,
    input  logic [4:0]               q_rs,
    output logic                     q_pending,
    output logic [$clog2(DEPTH):0]   ld_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // The pending query inspects every slot at once, so the FIFO storage is read
    // combinationally rather than through a registered RAM port.
    logic [4:0]      mem_rd   [DEPTH];
    logic [XLEN-1:0] mem_data [DEPTH];

    logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]   count_reg, count_next;
    logic            regw_reg, regw_next;
    logic [4:0]      rd_reg, rd_next;
    logic [XLEN-1:0] wd_reg, wd_next;

    logic            full, empty, push, pop, take_alu, sel_valid;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    logic [DEPTH-1:0] match;

    always_comb begin
        full      = (count_reg == CW'(DEPTH));
        empty     = (count_reg == '0);
        push      = ld_valid && !full;
        take_alu  = alu_valid && !full;
        pop       = full || (!alu_valid && !empty);
        sel_valid = pop || take_alu;
        sel_rd    = pop ? mem_rd[rd_ptr_reg]   : alu_rd;
        sel_data  = pop ? mem_data[rd_ptr_reg] : alu_data;

        wr_ptr_next = push ? wr_ptr_reg + AW'(1) : wr_ptr_reg;
        rd_ptr_next = pop  ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
        count_next  = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CW'(1);
        end

        // rd/wd hold when idle; an rd of zero is consumed without raising the write enable.
        regw_next = sel_valid && (sel_rd != 5'd0);
        rd_next   = sel_valid ? sel_rd   : rd_reg;
        wd_next   = sel_valid ? sel_data : wd_reg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            regw_reg   <= 1'b0;
            rd_reg     <= '0;
            wd_reg     <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            regw_reg   <= regw_next;
            rd_reg     <= rd_next;
            wd_reg     <= wd_next;
        end
    end

    // Slot contents need no reset: validity comes from the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wr_ptr_reg]   <= ld_rd;
            mem_data[wr_ptr_reg] <= ld_data;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            logic [AW-1:0] offset;
            assign offset    = AW'(gi) - rd_ptr_reg;
            assign match[gi] = ({1'b0, offset} < count_reg) && (mem_rd[gi] == q_rs);
        end
    endgenerate

    assign q_pending = (q_rs != 5'd0) && ((|match) || (regw_reg && (rd_reg == q_rs)));
    assign ld_ready  = !full;
    assign alu_ready = !full;
    assign ld_count  = count_reg;
    assign RegW      = regw_reg;
    assign Rd        = rd_reg;
    assign Wd        = wd_reg;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected writes are queued as stimulus is driven and
// matched against every observed register-file write; state is also checked inline.
module tb_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             alu_valid, ld_valid;
    logic             alu_ready, ld_ready;
    logic [4:0]       alu_rd, ld_rd, q_rs;
    logic [XLEN-1:0]  alu_data, ld_data;
    logic             RegW, q_pending;
    logic [4:0]       Rd;
    logic [XLEN-1:0]  Wd;
    logic [$clog2(DEPTH):0] ld_count;

    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q[$];

    wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .RegW(RegW), .Rd(Rd), .Wd(Wd),
        .q_rs(q_rs), .q_pending(q_pending), .ld_count(ld_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every write seen on the port must be the next expected one.
    always @(negedge clk) begin
        if (!reset && RegW) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL wb_unexpected observed rd=%0d wd=%0h expected none", Rd, Wd);
            end else begin
                check("wb_order", {27'd0, Rd, Wd}, {27'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        reset = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
        q_rs = 5'd5;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_regw", RegW, 1'b0);
        check("rst_rd", Rd, 5'd0);
        check("rst_wd", Wd, 32'd0);
        check("rst_count", ld_count, 3'd0);
        check("rst_ld_ready", ld_ready, 1'b1);
        check("rst_alu_ready", alu_ready, 1'b1);
        check("rst_pending", q_pending, 1'b0);
        $display("txn reset: idle state checked");

        // ALU only
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEADBEEF;
        exp_q.push_back({5'd3, 32'hDEADBEEF});
        step();
        alu_valid = 1'b0; q_rs = 5'd3;
        check("alu_regw", RegW, 1'b1);
        check("alu_rd", Rd, 5'd3);
        check("alu_wd", Wd, 32'hDEADBEEF);
        #1 check("alu_pending", q_pending, 1'b1);
        step();
        check("alu_regw_drop", RegW, 1'b0);
        $display("txn alu rd=3 data=deadbeef");

        // Load with ALU idle: two-cycle latency
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h1234;
        exp_q.push_back({5'd7, 32'h1234});
        step();
        ld_valid = 1'b0; q_rs = 5'd7;
        check("ld_count_e0", ld_count, 3'd1);
        check("ld_regw_e0", RegW, 1'b0);
        #1 check("ld_pending_fifo", q_pending, 1'b1);
        step();
        check("ld_regw_e1", RegW, 1'b1);
        check("ld_rd_e1", Rd, 5'd7);
        check("ld_count_e1", ld_count, 3'd0);
        $display("txn load rd=7 data=1234");

        // Priority and fill: ALU wins while loads queue up
        for (int i = 0; i < 4; i++) exp_q.push_back({5'(20 + i), 32'hA000 + i});
        exp_q.push_back({5'd8, 32'hB000});
        exp_q.push_back({5'd24, 32'hA004});
        for (int i = 1; i < 4; i++) exp_q.push_back({5'(8 + i), 32'hB000 + i});
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(20 + i); alu_data = 32'hA000 + i;
            ld_valid  = 1'b1; ld_rd  = 5'(8 + i);  ld_data  = 32'hB000 + i;
            step();
        end
        ld_valid = 1'b0;
        alu_rd = 5'd24; alu_data = 32'hA004; q_rs = 5'd11;
        #1;
        check("fill_count", ld_count, 3'd4);
        check("fill_ld_ready", ld_ready, 1'b0);
        check("fill_alu_ready", alu_ready, 1'b0);
        check("fill_pending", q_pending, 1'b1);
        step();
        q_rs = 5'd8;
        check("full_pop_rd", Rd, 5'd8);
        check("full_pop_count", ld_count, 3'd3);
        check("resume_alu_ready", alu_ready, 1'b1);
        #1 check("outreg_pending", q_pending, 1'b1);
        step();
        alu_valid = 1'b0;
        check("resume_alu_rd", Rd, 5'd24);
        repeat (3) step();
        check("drain_count", ld_count, 3'd0);
        $display("txn fill/drain: loads 8..11 with alu 20..24");

        // x0 handling
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
        step();
        alu_valid = 1'b0;
        check("x0_alu_regw", RegW, 1'b0);
        check("x0_alu_wd", Wd, 32'h55);
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h66;
        step();
        ld_valid = 1'b0; q_rs = 5'd0;
        check("x0_ld_count", ld_count, 3'd1);
        #1 check("x0_pending", q_pending, 1'b0);
        step();
        check("x0_ld_drain", ld_count, 3'd0);
        check("x0_ld_regw", RegW, 1'b0);
        $display("txn x0: alu and load to rd=0 consumed");

        // Async reset mid-operation
        exp_q.push_back({5'd25, 32'hC000});
        exp_q.push_back({5'd26, 32'hC001});
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(25 + i); alu_data = 32'hC000 + i;
            ld_valid  = 1'b1; ld_rd  = 5'(12 + i); ld_data  = 32'hD000 + i;
            step();
        end
        alu_valid = 1'b0; ld_valid = 1'b0;
        check("pre_rst_count", ld_count, 3'd3);
        check("pre_rst_regw", RegW, 1'b1);
        #1 reset = 1'b1;
        #1;
        check("arst_regw", RegW, 1'b0);
        check("arst_rd", Rd, 5'd0);
        check("arst_wd", Wd, 32'd0);
        check("arst_count", ld_count, 3'd0);
        repeat (2) step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            q_rs = 5'(12 + i);
            #1 check("post_rst_pending", q_pending, 1'b0);
        end
        repeat (5) step();
        check("post_rst_count", ld_count, 3'd0);
        check("sb_empty", exp_q.size(), 0);
        $display("txn async reset with 3 loads queued");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-side producer for the 32x32 register file write port (RegW/Rd/Wd).
- Merges single-cycle ALU results with late-returning load data, using a small load FIFO.
- Presents at most one registered write per cycle to the register file.
- Exposes a pending-write query so issue logic can stall on a register whose write is still in flight.

Parameters:
- DEPTH, 4, load FIFO entries; power of two, >=2.
- XLEN, 32, data width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- alu_valid  input  1  ALU result offered this cycle.
- alu_ready  output  1  ALU result accepted when alu_valid & alu_ready.
- alu_rd  input  5  ALU destination register.
- alu_data  input  XLEN  ALU result.
- ld_valid  input  1  load data offered this cycle.
- ld_ready  output  1  load accepted when ld_valid & ld_ready.
- ld_rd  input  5  load destination register.
- ld_data  input  XLEN  load data.
- RegW  output  1  register-file write enable (registered).
- Rd  output  5  register-file write address (registered).
- Wd  output  XLEN  register-file write data (registered).
- q_rs  input  5  register number to query.
- q_pending  output  1  q_rs has a write in FIFO or in the output register.
- ld_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - FIFO emptied; read/write pointers and ld_count = 0.
  - RegW = 0, Rd = 0, Wd = 0.
  - In-flight entries are discarded.
- ld_ready = (ld_count != DEPTH), purely from registered count.
  - No same-cycle push-through when full, even if a pop occurs that cycle.
- alu_ready = (ld_count != DEPTH).
- Selection each cycle, fixed priority:
  1. FIFO full: pop FIFO head; ALU is stalled.
  2. Else if alu_valid: take ALU.
  3. Else if FIFO not empty: pop FIFO head.
  4. Else: no write.
- Output register update at each edge:
  - RegW <= selected & (selected rd != 0).
  - Rd, Wd <= selected rd/data when something is selected; otherwise they hold their previous values.
  - A selected entry with rd = 0 is still consumed but produces RegW = 0, so x0 is never written.
- Latency:
  - ALU accepted at edge E gives RegW = 1 during the cycle after E.
  - Load accepted at edge E enters the FIFO at E. Earliest pop is in the cycle after E. RegW is visible after edge E+1, i.e. a minimum of 2 cycles.
- Simultaneous push and pop in the same cycle (FIFO not full): ld_count unchanged, order preserved.
- Pointers wrap modulo DEPTH. ld_count tracks full versus empty unambiguously.
- Ordering:
  - Loads retire in acceptance order.
  - ALU and loads may interleave.
  - Same-rd ordering between the ALU and load streams is the issuer's responsibility, using q_pending.
- q_pending (combinational from state and q_rs):
  - 1 if any valid FIFO entry has rd == q_rs.
  - Or if RegW = 1 and Rd == q_rs.
  - Forced 0 when q_rs == 0.
- ld_count: increments on push only, decrements on pop only, unchanged on both or neither.

Test Plan:
- Reset then idle -> RegW = 0, Rd = 0, Wd = 0, ld_count = 0, ld_ready = 1, alu_ready = 1, q_pending = 0 for q_rs = 5.
- ALU only: alu_valid one cycle with rd = 3, data = 0xDEADBEEF -> next cycle RegW = 1, Rd = 3, Wd = 0xDEADBEEF; the following cycle RegW = 0.
- Load with ALU idle: ld rd = 7, data = 0x1234 accepted at E0 -> ld_count = 1 after E0; RegW = 1, Rd = 7 after E1; ld_count = 0.
- Priority and fill, DEPTH = 4:
  - Continuous alu_valid plus 4 loads (rd 8–11) -> loads queue, ld_count = 4, ld_ready = 0, alu_ready = 0.
  - Next edge writes rd 8, then ALU resumes once ld_count = 3.
  - All loads eventually retire in order 8, 9, 10, 11.
- x0 handling:
  - alu_rd = 0 -> consumed, RegW stays 0.
  - ld_rd = 0 pushed and popped -> ld_count returns to 0, no write.
  - q_rs = 0 -> q_pending = 0.
- Async reset mid-operation:
  - With ld_count = 3 and RegW = 1, assert reset between edges -> outputs and ld_count go to 0 immediately, without waiting for clk.
  - After release, no stale writes appear.
  - q_pending = 0 for the formerly queued rd values.
